// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one step per clock).
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BIN_W      = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        value,
  output logic                    err
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_d;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] bin_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [BIN_W-1:0] value_q;
  logic             last_c;

  // Shift the whole {bcd,bin} chain right, then pull every digit >= 8 back by 3.
  always_comb begin
    bcd_shift = bcd_q >> 1;
    bin_d     = {bcd_q[0], bin_q[BIN_W-1:1]};
    bcd_d     = bcd_shift;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_shift[4*i+3]) begin
        bcd_d[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

  assign last_c = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q;
  logic invalid_c;

  always_comb begin
    invalid_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        invalid_c = 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
            if (invalid_c) begin
              state_q <= S_DONE;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
              value_q <= '0;
              err_q   <= 1'b1;
            end else begin
`endif
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
              bcd_q   <= bcd_in;
              bin_q   <= '0;
              cnt_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            end
`endif
          end
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            value_q <= bin_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign value = value_q;

endmodule
